// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU command path.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_EQ  = 3'b101;
  localparam logic [2:0] OP_GT  = 3'b110;
  localparam logic [2:0] OP_LT  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_A   = 3'd1,
    ST_GET_B   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_SEND_LO = 3'd5
  } seq_state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Byte-serial command/result streams between the host transport and the sequencer.
interface alu_cmd_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/cmd_timeout_counter.sv
// Inter-byte idle timer; expired is asserted on the cycle whose edge would make
// the count reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 removes the timer entirely.
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_cnt
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q;

      assign expired = enable && (cnt_q == LAST);

      // Expiry restarts the count so the pulse cannot repeat.
      always_ff @(posedge clk) begin
        if (!rst_n || clear || expired) begin
          cnt_q <= '0;
        end else if (enable) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end else begin : g_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects opcode/A/B bytes, drives the ALU from registers, returns the 16-bit
// result MSB first. Partial commands are dropped after an inter-byte timeout.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_IDLE    | waiting for opcode byte
//   ST_GET_A   | waiting for operand A byte
//   ST_GET_B   | waiting for operand B byte
//   ST_EXEC    | one cycle: capture ALU result and div_zero
//   ST_SEND_HI | presenting result[15:8]
//   ST_SEND_LO | presenting result[7:0]
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_cmd_sequencer_if.slave         bus,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic [2:0]                 alu_opcode,
  input  logic [15:0]                alu_result,
  output logic                       busy,
  output logic                       div_zero,
  output logic                       timeout_err
);

  seq_state_t  state_q;
  seq_state_t  state_d;
  logic [15:0] result_q;
  logic        in_get;
  logic        tmo_enable;
  logic        tmo_clear;
  logic        tmo_expired;

  // Ready is a pure state decode so no path exists from in_valid to in_ready.
  assign bus.in_ready = (state_q == ST_IDLE) || (state_q == ST_GET_A) || (state_q == ST_GET_B);
  assign in_get       = (state_q == ST_GET_A) || (state_q == ST_GET_B);
  assign tmo_enable   = in_get && !bus.in_valid;
  assign tmo_clear    = (state_q == ST_IDLE) || (in_get && bus.in_valid);

  assign bus.out_valid = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO);
  assign bus.out_data  = (state_q == ST_SEND_HI) ? result_q[15:8] :
                         (state_q == ST_SEND_LO) ? result_q[7:0]  : 8'h00;
  assign busy          = (state_q != ST_IDLE);

  cmd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (tmo_enable),
    .clear   (tmo_clear),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) state_d = ST_GET_A;
      end
      ST_GET_A: begin
        if (bus.in_valid)     state_d = ST_GET_B;
        else if (tmo_expired) state_d = ST_IDLE;
      end
      ST_GET_B: begin
        if (bus.in_valid)     state_d = ST_EXEC;
        else if (tmo_expired) state_d = ST_IDLE;
      end
      ST_EXEC: begin
        state_d = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        if (bus.out_ready) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ALU operand registers only move on an input accept; a timeout leaves them as-is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_opcode  <= 3'b000;
      result_q    <= 16'h0000;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_expired;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            alu_opcode <= bus.in_data[2:0];
            div_zero   <= 1'b0;
          end
        end
        ST_GET_A: begin
          if (bus.in_valid) alu_a <= bus.in_data;
        end
        ST_GET_B: begin
          if (bus.in_valid) alu_b <= bus.in_data;
        end
        ST_EXEC: begin
          result_q <= alu_result;
          div_zero <= is_div_op(alu_opcode) && (alu_b == 8'h00);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Byte-serial command front end for the ALU. It collects a 3-byte command (opcode, operand A, operand B) over a valid/ready input stream, drives the ALU operand/opcode inputs from registers, and captures the 16-bit combinational ALU result. It returns that result as two bytes, MSB first, over a valid/ready output stream. It sits between the byte transport (UART/host interface) and the ALU, feeding the ALU and consuming its result.

Parameters:
- TIMEOUT_CYCLES, 255, idle cycles allowed between command bytes before the partial command is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  8  command/operand byte
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts a byte this cycle
- out_data  out  8  result byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- alu_a  out  8  registered operand A to the ALU
- alu_b  out  8  registered operand B to the ALU
- alu_opcode  out  3  registered opcode to the ALU
- alu_result  in  16  combinational ALU result
- busy  out  1  high whenever state is not IDLE
- div_zero  out  1  last executed command was divide or modulo with B = 0
- timeout_err  out  1  one-cycle pulse when a partial command is aborted

Behaviour:
- Reset: one clock and a synchronous, active-low reset (rst_n sampled on the rising edge of clk). Reset forces state to IDLE and clears:
  - in_ready is 1 from the first cycle after reset.
  - out_valid=0, out_data=0x00.
  - alu_a=0, alu_b=0, alu_opcode=0.
  - busy=0, div_zero=0, timeout_err=0, timeout counter=0.
  - Reset at any point mid-command or mid-output discards all partial state; no output byte is emitted afterwards.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. in_ready=1 only in IDLE, GET_A and GET_B; in_ready is a decode of state only, with no combinational path from in_valid. out_valid=1 only in SEND_HI and SEND_LO. While out_valid=1 and out_ready=0, out_data holds stable.
- State machine: IDLE -> GET_A -> GET_B -> EXEC -> SEND_HI -> SEND_LO -> IDLE.
  - IDLE: on byte accept, alu_opcode <= in_data[2:0] (bits 7:3 reserved and ignored), div_zero <= 0, go to GET_A.
  - GET_A: on accept, alu_a <= in_data, go to GET_B.
  - GET_B: on accept, alu_b <= in_data, go to EXEC.
  - EXEC: exactly one cycle. result_reg <= alu_result; div_zero <= 1 if alu_opcode is 011 or 100 and alu_b == 0; go to SEND_HI.
  - SEND_HI: out_data = result_reg[15:8]; on out accept, go to SEND_LO.
  - SEND_LO: out_data = result_reg[7:0]; on out accept, go to IDLE.
- Latency: B accepted on edge t. out_valid=1 with the high byte from edge t+2. With out_ready held at 1, the sequencer returns to IDLE at edge t+4, so throughput is one command per 6 cycles minimum.
- ALU inputs change only on an input accept and are stable for the whole EXEC cycle.
- Arithmetic: no arithmetic in this block. The result is passed through unmodified, including the 0x0000 result for divide-by-zero and the 8-bit wrap of add/sub.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each cycle in GET_A or GET_B without an accept. It clears on any accept and on entering IDLE.
  - When it reaches TIMEOUT_CYCLES: state goes to IDLE, timeout_err pulses high for 1 cycle, and alu_* keep their values.
  - If a byte accept and the terminal count fall on the same edge, the accept wins and no timeout occurs.
  - No timeout applies in EXEC, SEND_HI or SEND_LO; output backpressure may last indefinitely.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- div_zero is sticky until the next opcode byte is accepted.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_DIV=011, OP_MOD=100, OP_EQ=101, OP_GT=110, OP_LT=111.
  - sequencer state encoding (6 states, 3-bit).
- One sub-module: cmd_timeout_counter. Inputs: clk, rst_n, enable, clear. Output: expired. Parameterised by TIMEOUT_CYCLES.
- The ALU is instantiated beside this block at top level, not inside it.

Test Plan:
- Add: bytes 0x00,0x7F,0x01, out_ready=1 -> out bytes 0x00 then 0x80; div_zero=0; out_valid first high 2 edges after B accept.
- Sub wrap and mul: 0x01,0x05,0x0A -> 0x00,0xFB. Then 0x02,0xFF,0xFF -> 0xFE,0x01. Reserved bits: 0xF8,0x03,0x04 -> executes as add -> 0x00,0x07.
- Divide by zero: 0x03,0x10,0x00 -> 0x00,0x00 and div_zero=1 from EXEC onward. div_zero returns to 0 on the edge accepting the next opcode byte.
- Backpressure: mul 0xFF*0xFF with out_ready=0 for 5 cycles in SEND_HI -> out_data held at 0xFE, out_valid=1, in_ready=0. Then 0xFE,0x01 delivered, no duplication or loss.
- Timeout (TIMEOUT_CYCLES=16): send 0x00,0x11, then in_valid=0 for 16 cycles -> one-cycle timeout_err, in_ready=1, busy=0. Next 0x00,0x02,0x03 -> 0x00,0x05. Also check a byte on the 16th idle cycle is accepted with no pulse.
- Reset mid-operation: assert rst_n=0 for 1 cycle while in SEND_HI -> out_valid=0, busy=0, alu_a/alu_b/alu_opcode=0, in_ready=1 next cycle, low byte never emitted.
